pkt_port_arbiter: RTL
=====================

Name: pkt_port_arbiter

Overview:
- Packet-granular round-robin arbiter for one output port of the packet switch DUT.
- Sits in front of the output mux. NUM_REQ input ports contend for the output; each declares its payload length in bytes when it requests.
- The winner holds the grant until exactly len bytes have transferred. The grant then releases and the round-robin pointer advances.
- The arbiter drives the mux select and the per-byte transfer strobe.

Parameters:
- NUM_REQ, 4, number of requesting input ports.
- LEN_W, 8, width of the declared payload length field.
- MAX_PAYLOAD, 255, largest legal payload in bytes.
- TIMEOUT_CYC, 64, stall limit for the watchdog (only used with WATCHDOG_EN).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-port request, held until that port's grant ends.
- len  in  NUM_REQ*LEN_W  per-port payload length, port i at bits [i*LEN_W +: LEN_W]; must be stable while req[i] is high.
- src_valid  in  NUM_REQ  per-port data byte valid.
- out_ready  in  1  downstream accepts a byte this cycle.
- gnt  out  NUM_REQ  one-hot grant, registered.
- gnt_id  out  $clog2(NUM_REQ)  index of the granted port (mux select), registered.
- busy  out  1  high while a grant is active.
- xfer  out  1  byte transferred this cycle; combinational: busy & src_valid[gnt_id] & out_ready.
- last  out  1  high with the final xfer of a packet.
- len_err  out  1  one-cycle pulse when a granted length is 0 or > MAX_PAYLOAD.
- timeout  out  1  one-cycle pulse on a watchdog abort; tied 0 without WATCHDOG_EN.

Behaviour:
- Reset (reset low, asynchronous):
  - gnt=0, gnt_id=0, busy=0, len_err=0, timeout=0.
  - Byte count=0, round-robin pointer=0, state=IDLE.
  - A reset mid-packet drops the grant immediately; no last is issued.
- States: IDLE, XFER, ERR.
- IDLE:
  - If any req is set, pick the first set req starting at the pointer, wrapping modulo NUM_REQ.
  - Next edge: gnt/gnt_id/busy register the choice, len is latched into len_q, and count is cleared.
  - Go to ERR if len_q==0 or len_q>MAX_PAYLOAD; otherwise go to XFER.
  - Latency from req to gnt is 1 cycle.
- XFER:
  - Each cycle with xfer high, count increments.
  - last = xfer & (count == len_q-1).
  - On last, the next edge clears gnt/busy, sets pointer=gnt_id+1 (mod NUM_REQ) and returns to IDLE.
  - There is one IDLE cycle between packets; this is the minimum inter-packet gap.
- ERR:
  - For one cycle, gnt is still high, len_err=1 and xfer is forced to 0.
  - Next edge: clear the grant, advance the pointer, go to IDLE.
- req changes during a grant are ignored. Dropping req[gnt_id] mid-packet does not end the grant.
- The count is LEN_W bits wide and never wraps, because len_q ≤ MAX_PAYLOAD ≤ 2^LEN_W-1.
- If the granted port asserts src_valid while out_ready is low, there is no transfer and the count holds.

Optional Feature:
- Macro: PKT_ARB_WATCHDOG_EN.
- Defined:
  - A stall counter counts consecutive XFER cycles with xfer=0 and clears on any xfer.
  - When it reaches TIMEOUT_CYC, the next edge pulses timeout for 1 cycle, clears the grant, advances the pointer and returns to IDLE. No last is issued.
- Undefined:
  - No stall counter; XFER waits indefinitely.
  - timeout is tied 0.

Decomposition:
- Package pkt_arb_pkg holds:
  - the state enum arb_state_e {IDLE, XFER, ERR};
  - the default NUM_REQ, LEN_W and MAX_PAYLOAD constants;
  - an id_t typedef sized $clog2(NUM_REQ).
- Sub-module rr_pick: combinational. Inputs req and pointer; outputs a one-hot pick plus its index. Instantiated once.

Test Plan:
- Single port: req[2]=1, len=4, src_valid/out_ready high → gnt=4'b0100 one cycle later; xfer for 4 cycles; last on the 4th; busy drops the next cycle; pointer=3.
- Contention: req=4'b1111, each len=2, pointer=0 → grants in order 0,1,2,3,0; each grant has 2 xfer and 1 idle gap.
- Backpressure: len=3, out_ready toggles 1,0,1,0,1 → count holds on ready-low cycles; last on the 3rd accepted byte; no extra xfer.
- Min/max payload:
  - len=1 → xfer and last in the same cycle.
  - len=255 → exactly 255 xfer.
  - len=0 → len_err pulse, no xfer, grant released next cycle.
- Reset mid-packet: assert reset low after 5 of 10 bytes → gnt=0, busy=0 immediately; after release, req[1] wins (pointer=0 cleared).
- Watchdog (PKT_ARB_WATCHDOG_EN, TIMEOUT_CYC=64): granted port holds src_valid=0 → timeout pulses after 64 stall cycles, grant released, next requester granted.

Source files
------------

// File: rtl/pkt_arb_pkg.sv
// pkt_arb_pkg: shared state type, id type and default sizing for the packet port arbiter.
package pkt_arb_pkg;
    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_LEN_W       = 8;
    localparam int DEF_MAX_PAYLOAD = 255;
    typedef enum logic [1:0] {IDLE, XFER, ERR} arb_state_e;
    typedef logic [$clog2(DEF_NUM_REQ)-1:0] id_t;
endpackage

// File: rtl/pkt_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [ID_W-1:0]    pick_id
);
    // Scan from farthest to nearest so the nearest set request wins.
    always_comb begin
        pick_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NUM_REQ]) pick_id = ID_W'((int'(ptr) + i) % NUM_REQ);
        end
        pick = '0;
        pick[pick_id] = |req;
    end
endmodule

// File: rtl/pkt_port_arbiter.sv
// pkt_port_arbiter: packet-granular round-robin arbiter for one switch output port.
// Define PKT_ARB_WATCHDOG_EN to abort packets that stall for TIMEOUT_CYC cycles.
module pkt_port_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int LEN_W       = DEF_LEN_W,
    parameter int MAX_PAYLOAD = DEF_MAX_PAYLOAD
`ifdef PKT_ARB_WATCHDOG_EN
    , parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*LEN_W-1:0]   len,
    input  logic [NUM_REQ-1:0]         src_valid,
    input  logic                       out_ready,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       xfer,
    output logic                       last,
    output logic                       len_err,
    output logic                       timeout
);
    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e         state, state_d;
    logic [NUM_REQ-1:0] pick;
    logic [ID_W-1:0]    pick_id, ptr, gnt_nxt;
    logic [LEN_W-1:0]   len_q, cnt, len_sel;
    logic               bad_len, abort, done;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req(req),
        .ptr(ptr),
        .pick(pick),
        .pick_id(pick_id)
    );

    assign len_sel = len[pick_id*LEN_W +: LEN_W];
    assign bad_len = len_sel == '0 || {1'b0, len_sel} > (LEN_W+1)'(MAX_PAYLOAD);
    assign busy    = state != IDLE;
    assign xfer    = state == XFER && src_valid[gnt_id] && out_ready;
    assign last    = xfer && cnt == len_q - 1'b1;
    assign len_err = state == ERR;
    assign done    = last || abort || state == ERR;
    assign gnt_nxt = gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (|req) state_d = bad_len ? ERR : XFER;
            XFER:    if (last || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt    <= '0;
            gnt_id <= '0;
            ptr    <= '0;
            len_q  <= '0;
            cnt    <= '0;
        end else if (state == IDLE && |req) begin
            gnt    <= pick;
            gnt_id <= pick_id;
            len_q  <= len_sel;
            cnt    <= '0;
        end else if (done) begin
            gnt <= '0;
            ptr <= gnt_nxt;
        end else if (xfer) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef PKT_ARB_WATCHDOG_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC + 1);
    logic [ST_W-1:0] stall;
    // Abort on the TIMEOUT_CYC-th consecutive idle XFER cycle; timeout pulses as the grant drops.
    assign abort = state == XFER && !xfer && stall == ST_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall   <= '0;
            timeout <= 1'b0;
        end else begin
            stall   <= (state == XFER && !xfer && !abort) ? stall + 1'b1 : '0;
            timeout <= abort;
        end
    end
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule
